// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    // Active-high segment pattern: bits 6:0 = a..g, bit 7 = DP.
    typedef logic [7:0] seg_t;

    localparam seg_t SEG_DARK  = 8'hFF;
    localparam seg_t SEG_CLEAR = 8'h00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_dwell_timer.sv
// Load / terminal-count down counter, shared by the blank and dwell phases.
module seg7_dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Holds at zero once the terminal count is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed 7-segment scanner with a shadow pattern buffer that is copied
// into the displayed buffer atomically at frame boundaries.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_OF_DISPLAYS = 6,
    parameter int DWELL_CYCLES    = 50000,
    parameter int BLANK_CYCLES    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [2:0]                 wr_idx_i,
    input  logic [7:0]                 wr_seg_i,
    input  logic                       commit_i,
    output logic [NUM_OF_DISPLAYS-1:0] an_o,
    output logic [7:0]                 seg_o,
    output logic                       frame_done_o,
    output logic                       commit_pending_o
);

    localparam int             CNT_W      = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES));
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]     LAST_IDX   = 3'(NUM_OF_DISPLAYS - 1);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    seg_t             shadow_q [NUM_OF_DISPLAYS];
    seg_t             shadow_d [NUM_OF_DISPLAYS];
    seg_t             active_q [NUM_OF_DISPLAYS];
    seg_t             active_d [NUM_OF_DISPLAYS];

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;
    logic             frame_done;
    logic             copy_now;
    logic             wr_fire;

    seg7_dwell_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tmr_load = 1'b1;
                idx_d    = '0;
                if (enable_i) begin
                    state_d = ST_BLANK;
                    tmr_val = BLANK_LOAD;
                end
            end
            ST_BLANK: begin
                if (!enable_i) begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    state_d  = ST_DRIVE;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LOAD;
                end
            end
            ST_DRIVE: begin
                if (!enable_i) begin
                    state_d  = ST_IDLE;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end else if (tmr_tc) begin
                    state_d  = ST_BLANK;
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LOAD;
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                idx_d    = '0;
                tmr_load = 1'b1;
            end
        endcase
    end

    // While idle no frame is on screen, so a pending commit lands immediately.
    assign copy_now  = pending_q && ((state_q == ST_IDLE) || frame_done);
    assign pending_d = copy_now ? 1'b0 : (pending_q | commit_i);
    assign wr_fire   = wr_valid_i && !copy_now;

    // Out-of-range indices match no entry, so such writes vanish silently.
    always_comb begin
        for (int i = 0; i < NUM_OF_DISPLAYS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = copy_now ? shadow_q[i] : active_q[i];
            if (wr_fire && (wr_idx_i == 3'(i))) begin
                shadow_d[i] = wr_seg_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < NUM_OF_DISPLAYS; i++) begin
                shadow_q[i] <= SEG_CLEAR;
                active_q[i] <= SEG_CLEAR;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            for (int i = 0; i < NUM_OF_DISPLAYS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    always_comb begin
        an_o  = '1;
        seg_o = SEG_DARK;
        if (state_q == ST_DRIVE) begin
            an_o[idx_q] = 1'b0;
            seg_o       = ~active_q[idx_q];
        end
    end

    assign wr_ready_o       = !copy_now;
    assign frame_done_o     = frame_done;
    assign commit_pending_o = pending_q;

endmodule
